// File: rtl/switch_gate_pkg.sv
// Shared mode encoding for the switch/LED gate array.
package switch_gate_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_AND    = 2'd0;
    localparam mode_t MODE_OR     = 2'd1;
    localparam mode_t MODE_XOR    = 2'd2;
    localparam mode_t MODE_TOGGLE = 2'd3;

endpackage

// File: rtl/switch_gate_array_debounce.sv
// Single-channel switch conditioner: two-flop synchroniser followed by a
// counter that only accepts a new level after it has held for DEBOUNCE_LIMIT cycles.
module debounce_filter
    import switch_gate_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Switch,
    output logic o_Stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;

    // Any return to the stable level restarts the count, so short glitches never qualify.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            count    <= '0;
            o_Stable <= 1'b0;
        end else begin
            sync1 <= i_Switch;
            sync2 <= sync1;
            if (sync2 == o_Stable) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                o_Stable <= sync2;
                count    <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_gate_array.sv
// N debounced switches driving N registered LEDs through a run-time selectable
// ring-neighbour gate (AND/OR/XOR) or a per-channel toggle latch.
module switch_gate_array
    import switch_gate_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic [1:0]        i_Mode,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Stable
);

    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] stable_d;
    logic [NUM_CH-1:0] tog;
    logic [NUM_CH-1:0] neighbour;
    logic [NUM_CH-1:0] next_led;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        debounce_filter #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_debounce (
            .i_Clk   (i_Clk),
            .i_Rst_n (i_Rst_n),
            .i_Switch(i_Switch[k]),
            .o_Stable(stable[k])
        );
    end

    assign o_Stable  = stable;
    assign neighbour = {stable[0], stable[NUM_CH-1:1]};

    // Toggle latches run in every mode so their state is current on entering TOGGLE.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            stable_d <= '0;
            tog      <= '0;
        end else begin
            stable_d <= stable;
            tog      <= tog ^ (stable & ~stable_d);
        end
    end

    always_comb begin
        next_led = tog;
        case (mode_t'(i_Mode))
            MODE_AND:    next_led = stable & neighbour;
            MODE_OR:     next_led = stable | neighbour;
            MODE_XOR:    next_led = stable ^ neighbour;
            MODE_TOGGLE: next_led = tog;
            default:     next_led = tog;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_LED <= '0;
        end else begin
            o_LED <= next_led;
        end
    end

endmodule

// File: tb/tb_switch_gate_array.sv
// Directed bench for switch_gate_array (NUM_CH=4, DEBOUNCE_LIMIT=4) using a
// cycle-stamped scoreboard of expected o_LED / o_Stable values.
module tb_switch_gate_array;

    localparam int NUM_CH = 4;
    localparam int DEBOUNCE_LIMIT = 4;

    typedef struct {
        string    tag;
        int       due;
        bit       is_led;
        logic [3:0] value;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic [1:0] mode;
    logic [3:0] led;
    logic [3:0] stable;

    exp_t scoreboard[$];
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    switch_gate_array #(
        .NUM_CH        (NUM_CH),
        .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_Switch(sw),
        .i_Mode  (mode),
        .o_LED   (led),
        .o_Stable(stable)
    );

    task automatic push_exp(input string tag, input bit is_led, input logic [3:0] value,
                            input int delay);
        exp_t e;
        e.tag    = tag;
        e.due    = cycle + delay;
        e.is_led = is_led;
        e.value  = value;
        scoreboard.push_back(e);
    endtask

    task automatic check_output();
        exp_t       e;
        logic [3:0] observed;
        while (scoreboard.size() > 0 && scoreboard[0].due <= cycle) begin
            e = scoreboard.pop_front();
            observed = e.is_led ? led : stable;
            checks++;
            assert (observed === e.value && e.due == cycle) else begin
                errors++;
                $error("[TB] FAIL %s: observed %b at cycle %0d, expected %b at cycle %0d",
                       e.tag, observed, cycle, e.value, e.due);
            end
        end
    endtask

    task automatic apply_stimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cycle++;
            check_output();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        sw    = 4'b1111;
        mode  = 2'd0;
        #2;
        push_exp("reset_led_async", 1'b1, 4'b0000, 0);
        push_exp("reset_stable_async", 1'b0, 4'b0000, 0);
        check_output();

        // Test 1: release reset with all switches high
        apply_stimulus(2);
        rst_n = 1'b1;
        push_exp("t1_stable_pre", 1'b0, 4'b0000, 5);
        push_exp("t1_stable", 1'b0, 4'b1111, 6);
        push_exp("t1_led_pre", 1'b1, 4'b0000, 6);
        push_exp("t1_led_and", 1'b1, 4'b1111, 7);
        apply_stimulus(8);

        // Test 2: AND mode with ring wrap
        sw = 4'b0011;
        push_exp("t2_stable_0011", 1'b0, 4'b0011, 6);
        push_exp("t2_led_old", 1'b1, 4'b1111, 6);
        push_exp("t2_led_0001", 1'b1, 4'b0001, 7);
        apply_stimulus(8);
        sw = 4'b1001;
        push_exp("t2_stable_1001", 1'b0, 4'b1001, 6);
        push_exp("t2_led_wrap", 1'b1, 4'b1000, 7);
        apply_stimulus(8);

        // Test 3: OR mode, short and long glitches on channel 2
        mode = 2'd1;
        push_exp("t3_led_or", 1'b1, 4'b1101, 1);
        apply_stimulus(2);
        sw = 4'b1101;
        push_exp("t3_glitch3_stable", 1'b0, 4'b1001, 10);
        push_exp("t3_glitch3_led", 1'b1, 4'b1101, 10);
        apply_stimulus(3);
        sw = 4'b1001;
        apply_stimulus(7);
        sw = 4'b1101;
        push_exp("t3_pulse5_pre", 1'b0, 4'b1001, 5);
        push_exp("t3_pulse5_stable", 1'b0, 4'b1101, 6);
        push_exp("t3_pulse5_led", 1'b1, 4'b1111, 7);
        push_exp("t3_pulse5_back", 1'b0, 4'b1001, 14);
        push_exp("t3_pulse5_led_back", 1'b1, 4'b1101, 14);
        apply_stimulus(5);
        sw = 4'b1001;
        apply_stimulus(9);

        // Test 4: XOR then immediate switch to AND
        mode = 2'd2;
        sw   = 4'b0101;
        push_exp("t4_stable_0101", 1'b0, 4'b0101, 6);
        push_exp("t4_led_xor", 1'b1, 4'b1111, 7);
        apply_stimulus(8);
        mode = 2'd0;
        push_exp("t4_led_and", 1'b1, 4'b0000, 1);
        apply_stimulus(1);
        mode = 2'd2;
        push_exp("t4_led_xor_again", 1'b1, 4'b1111, 1);
        apply_stimulus(1);

        // Asynchronous clear with non-zero state, then start TOGGLE from a clean slate
        #2;
        rst_n = 1'b0;
        sw    = 4'b0000;
        #1;
        push_exp("rst_led_async", 1'b1, 4'b0000, 0);
        push_exp("rst_stable_async", 1'b0, 4'b0000, 0);
        check_output();
        mode = 2'd3;
        apply_stimulus(2);
        rst_n = 1'b1;
        push_exp("t5_led_init", 1'b1, 4'b0000, 1);
        apply_stimulus(2);

        // Test 5: three presses of switch 1 in TOGGLE mode
        for (int p = 0; p < 3; p++) begin
            sw = 4'b0010;
            push_exp("t5_press_pre", 1'b1, (p % 2 == 0) ? 4'b0000 : 4'b0010, 7);
            push_exp("t5_press", 1'b1, (p % 2 == 0) ? 4'b0010 : 4'b0000, 8);
            apply_stimulus(10);
            sw = 4'b0000;
            push_exp("t5_release", 1'b1, (p % 2 == 0) ? 4'b0010 : 4'b0000, 10);
            apply_stimulus(10);
        end
        mode = 2'd0;
        push_exp("t5_led_and", 1'b1, 4'b0000, 1);
        apply_stimulus(1);
        mode = 2'd3;
        push_exp("t5_led_retained", 1'b1, 4'b0010, 1);
        apply_stimulus(1);

        // Test 6: reset in the middle of a debounce
        sw = 4'b0001;
        apply_stimulus(3);
        rst_n = 1'b0;
        #1;
        push_exp("t6_led_async", 1'b1, 4'b0000, 0);
        check_output();
        apply_stimulus(1);
        rst_n = 1'b1;
        push_exp("t6_stable_pre", 1'b0, 4'b0000, 5);
        push_exp("t6_stable", 1'b0, 4'b0001, 6);
        push_exp("t6_led_pre", 1'b1, 4'b0000, 7);
        push_exp("t6_led_toggle", 1'b1, 4'b0001, 8);
        apply_stimulus(9);

        checks++;
        assert (scoreboard.size() === 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain: observed %0d pending, expected 0",
                   scoreboard.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_gate_array.md
Name: switch_gate_array

Overview:
- Parametrised successor to the fixed four-switch/four-LED gate block.
- N switch inputs are synchronised and debounced. They then drive N registered LED outputs.
- Run-time mode select: ring-adjacent AND, OR or XOR, or a per-channel toggle latch.
- Sits directly between board switch pins and LED pins. Top-level instantiates it with NUM_CH=4.

Parameters:
- NUM_CH, 4, number of switch/LED channels; legal range 2..32.
- DEBOUNCE_LIMIT, 250000, consecutive cycles a synchronised input must differ from its stable value before the stable value updates; legal range >= 1.

Ports:
- i_Clk  input  1  system clock; all state is on the rising edge.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_Switch  input  NUM_CH  raw switch levels, asynchronous to i_Clk.
- i_Mode  input  2  operating mode, sampled every cycle: 0=AND, 1=OR, 2=XOR, 3=TOGGLE.
- o_LED  output  NUM_CH  registered LED drive.
- o_Stable  output  NUM_CH  debounced switch levels, for status and debug.

Behaviour:
- Reset: while i_Rst_n=0, every register is 0 immediately, without waiting for a clock edge. This covers sync flops, debounce counters, stable levels, toggle latches, o_LED and o_Stable. On the first rising edge after i_Rst_n rises, normal operation begins.
- Synchronisation: each i_Switch bit passes through 2 flops (sync1, sync2).
- Debounce, per channel:
  - Counter width is clog2(DEBOUNCE_LIMIT+1).
  - If sync2 == stable, the counter clears to 0.
  - Else, if counter == DEBOUNCE_LIMIT-1, stable <= sync2 and the counter clears to 0.
  - Else, the counter increments.
  - A glitch shorter than DEBOUNCE_LIMIT cycles never reaches stable, because the counter restarts on every return to the stable value.
  - The counter never exceeds DEBOUNCE_LIMIT-1 and never wraps.
- o_Stable equals the stable register, with no extra stage.
- Gate modes: index k+1 wraps to 0, so k = NUM_CH-1 pairs with channel 0.
  - AND: o_LED[k] <= stable[k] & stable[k+1].
  - OR: o_LED[k] <= stable[k] | stable[k+1].
  - XOR: o_LED[k] <= stable[k] ^ stable[k+1].
- TOGGLE mode: o_LED[k] <= tog[k].
- Toggle latches:
  - tog[k] flips on every cycle in which stable[k] rises 0->1. Rise detection compares against a 1-cycle delayed copy of stable.
  - The latches update in all modes. The latch state is therefore retained and current when TOGGLE is entered.
- Latency:
  - Switch change to o_Stable: DEBOUNCE_LIMIT+2 cycles.
  - Switch change to o_LED in a gate mode: DEBOUNCE_LIMIT+3 cycles.
  - Switch change to o_LED in TOGGLE mode: DEBOUNCE_LIMIT+4 cycles, because of the edge-detect stage.
- Mode change: o_LED reflects the new mode on the next rising edge. No debounce or toggle state is disturbed.
- Simultaneous events: channels are fully independent. Several channels debouncing or toggling in the same cycle each update independently.
- Reset mid-debounce: the partial count is discarded. After reset, stable starts at 0 regardless of the switch level, and a held-high switch re-qualifies after DEBOUNCE_LIMIT+2 cycles.

Decomposition:
- Package switch_gate_pkg holds:
  - mode localparams MODE_AND=2'd0, MODE_OR=2'd1, MODE_XOR=2'd2, MODE_TOGGLE=2'd3;
  - a typedef for the 2-bit mode.
- One sub-module, debounce_filter: a single channel containing the sync flops, counter and stable register, with parameter DEBOUNCE_LIMIT. It is instantiated NUM_CH times via generate.
- The gate/toggle logic stays in switch_gate_array.

Test Plan (NUM_CH=4, DEBOUNCE_LIMIT=4 unless stated):
1. Reset: hold i_Rst_n=0 with i_Switch=4'b1111 -> o_LED=0 and o_Stable=0 asynchronously. Release reset -> o_Stable=4'b1111 exactly 6 cycles after the first post-reset edge.
2. AND mode, i_Switch=4'b0011 held -> o_LED=4'b0001 at DEBOUNCE_LIMIT+3=7 cycles. Then i_Switch=4'b1001 -> o_LED=4'b1000 (LED3 = ch3 & ch0).
3. Glitch: in mode OR, pulse i_Switch[2] high for 3 cycles -> o_Stable and o_LED unchanged. A 5-cycle pulse -> o_Stable[2]=1 at cycle 6.
4. XOR mode, i_Switch=4'b0101 -> o_LED=4'b1111. Switch i_Mode to AND -> o_LED=4'b0000 on the next edge.
5. TOGGLE: press and release i_Switch[1] three times, each level held 10 cycles -> o_LED[1]=1,0,1 after each press, other bits 0. Switch to AND and back to TOGGLE -> o_LED[1]=1 retained.
6. Reset mid-debounce: drive i_Switch[0]=1, assert i_Rst_n=0 after 3 cycles, release -> o_Stable[0]=1 only 6 cycles after release.
